// File: rtl/refresh_scheduler_pkg.sv
// Shared types, width helpers and parameter legality for the DRAM refresh scheduler.
package refresh_pkg;

  typedef enum logic {
    PH_INIT,
    PH_RUN
  } phase_t;

  function automatic int debt_w(input int max_debt);
    return $clog2(max_debt + 1);
  endfunction

  function automatic int tmr_w(input int interval);
    return $clog2(interval);
  endfunction

  // Default-configuration widths (390-clock interval, debt limit of 8).
  localparam int DEBT_W = debt_w(8);
  localparam int TMR_W  = tmr_w(390);

  function automatic bit params_ok(input int interval, input int max_debt,
                                   input int urgent_th, input int init_refs);
    return (interval >= 2) && (urgent_th >= 1) && (urgent_th <= max_debt) &&
           (init_refs >= 0) && (init_refs <= max_debt);
  endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Refresh request/acknowledge bundle between the scheduler and the DRAM controller.
interface refresh_scheduler_if #(
  parameter int DEBT_W = 4
);
  logic              RefAck;
  logic              OvrClr;
  logic              RefReq;
  logic              RefUrgent;
  logic              InitDone;
  logic              Overrun;
  logic [DEBT_W-1:0] Debt;

  modport master (
    input  RefAck, OvrClr,
    output RefReq, RefUrgent, InitDone, Overrun, Debt
  );

  modport slave (
    output RefAck, OvrClr,
    input  RefReq, RefUrgent, InitDone, Overrun, Debt
  );
endinterface

// File: rtl/refresh_scheduler_timer.sv
// Reloadable interval down-counter; one-cycle tick every INTERVAL clocks unless held.
module refresh_interval_timer #(
  parameter int INTERVAL = 390,
  parameter int TMR_W    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(INTERVAL - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q - TMR_W'(1);
    if (hold || (tmr_q == '0)) tmr_d = RELOAD;
  end

  assign tick = !hold && (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= RELOAD;
    else        tmr_q <= tmr_d;
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh debt tracker: periodic ticks add debt, RefAck rising edges pay it off.
//   phase   | meaning
//   PH_INIT | power-up refresh burst outstanding, interval timer held
//   PH_RUN  | normal operation, periodic ticks accumulate debt
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int INTERVAL  = 390,
  parameter int MAX_DEBT  = 8,
  parameter int URGENT_TH = 2,
  parameter int INIT_REFS = 8
) (
  input logic                 CLK,
  input logic                 nRESET,
  refresh_scheduler_if.master ref_if
);

  localparam int DW = debt_w(MAX_DEBT);
  localparam int TW = tmr_w(INTERVAL);

  localparam logic [DW-1:0] DEBT_MAX  = DW'(MAX_DEBT);
  localparam logic [DW-1:0] DEBT_URG  = DW'(URGENT_TH);
  localparam logic [DW-1:0] DEBT_INIT = DW'(INIT_REFS);
  localparam phase_t        PHASE_RST = (INIT_REFS > 0) ? PH_INIT : PH_RUN;

  if (!params_ok(INTERVAL, MAX_DEBT, URGENT_TH, INIT_REFS)) begin : g_param_err
    $error("refresh_scheduler: illegal parameter combination");
  end

  phase_t          phase_q, phase_d;
  logic [DW-1:0]   debt_q, debt_d;
  logic            ack_q, ack_d;
  logic            ovr_q, ovr_d;
  logic            req_q, req_d;
  logic            urg_q, urg_d;
  logic            done_q, done_d;
  logic            tick;
  logic            ack_edge;
  logic            ovr_set;

  refresh_interval_timer #(
    .INTERVAL (INTERVAL),
    .TMR_W    (TW)
  ) u_timer (
    .clk   (CLK),
    .rst_n (nRESET),
    .hold  (phase_q == PH_INIT),
    .tick  (tick)
  );

  assign ack_edge = ref_if.RefAck && !ack_q;

  always_comb begin
    phase_d = phase_q;
    debt_d  = debt_q;
    ack_d   = ref_if.RefAck;
    ovr_set = 1'b0;

    // A tick and an ack edge in the same cycle cancel out.
    if (tick && !ack_edge) begin
      if (debt_q < DEBT_MAX) debt_d  = debt_q + DW'(1);
      else                   ovr_set = 1'b1;
    end else if (ack_edge && !tick) begin
      if (debt_q != '0) debt_d = debt_q - DW'(1);
      if ((phase_q == PH_INIT) && (debt_q == DW'(1))) phase_d = PH_RUN;
    end

    ovr_d = ovr_q;
    if (ovr_set)            ovr_d = 1'b1;
    else if (ref_if.OvrClr) ovr_d = 1'b0;

    // Outputs are registered from next state so they track debt with one-cycle latency.
    req_d  = (debt_d != '0);
    urg_d  = ((phase_d == PH_INIT) && (debt_d != '0)) ||
             ((phase_d == PH_RUN) && (debt_d >= DEBT_URG));
    done_d = (phase_d == PH_RUN);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      phase_q <= PHASE_RST;
      debt_q  <= DEBT_INIT;
      ack_q   <= 1'b1;
      ovr_q   <= 1'b0;
      req_q   <= (INIT_REFS > 0);
      urg_q   <= (INIT_REFS > 0);
      done_q  <= (INIT_REFS == 0);
    end else begin
      phase_q <= phase_d;
      debt_q  <= debt_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      req_q   <= req_d;
      urg_q   <= urg_d;
      done_q  <= done_d;
    end
  end

  assign ref_if.RefReq    = req_q;
  assign ref_if.RefUrgent = urg_q;
  assign ref_if.InitDone  = done_q;
  assign ref_if.Overrun   = ovr_q;
  assign ref_if.Debt      = debt_q;

endmodule

// File: doc/refresh_scheduler.md
Name: refresh_scheduler

Overview:
- Sources the refresh-request interface (RefReq, RefUrgent, RefAck) consumed by the DRAM controller in the CPLD.
- Generates periodic refresh ticks and tracks outstanding refresh debt, up to the DRAM's postponement limit.
- Escalates to urgent when the debt grows, and runs the power-up initialisation refresh burst before reporting DRAM ready.

Parameters:
- INTERVAL, 390, clocks between refresh ticks (15.6 us at 25 MHz); must be >= 2.
- MAX_DEBT, 8, maximum outstanding refreshes; debt saturates here.
- URGENT_TH, 2, debt at or above this asserts RefUrgent in RUN; 1 <= URGENT_TH <= MAX_DEBT.
- INIT_REFS, 8, refreshes required after reset before InitDone; 0 <= INIT_REFS <= MAX_DEBT.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- nRESET  in  1  asynchronous active-low reset.
- RefAck  in  1  refresh RAS active from the DRAM controller; may stay high for several cycles per refresh.
- OvrClr  in  1  synchronous clear of the Overrun flag.
- RefReq  out  1  at least one refresh outstanding.
- RefUrgent  out  1  refresh must preempt RAM access.
- InitDone  out  1  power-up refresh burst complete.
- Overrun  out  1  sticky: a tick arrived with debt already at MAX_DEBT.
- Debt  out  clog2(MAX_DEBT+1)  current outstanding refresh count, for debug.

Behaviour:
- State: Phase {INIT, RUN}; Debt counter; interval down-counter Tmr; AckQ (previous RefAck); Overrun.
- Reset (async, while nRESET=0):
  - Phase=INIT if INIT_REFS>0, else RUN.
  - Debt=INIT_REFS, Tmr=INTERVAL-1, AckQ=1, Overrun=0.
- Outputs are combinational decodes of registered state:
  - RefReq = (Debt != 0).
  - RefUrgent = (Phase==INIT && Debt!=0) || (Phase==RUN && Debt>=URGENT_TH).
  - InitDone = (Phase==RUN).
  - Reset values: RefReq = RefUrgent = (INIT_REFS>0); InitDone = (INIT_REFS==0); Overrun=0.
- Ack edge: AckEdge = RefAck && !AckQ; AckQ <= RefAck every cycle.
  - Exactly one decrement per RefAck high pulse, whatever its length.
  - Reset value AckQ=1, so an ack already high at reset release is not counted.
- Timer:
  - In INIT, Tmr is held at INTERVAL-1 and no ticks occur.
  - In RUN, Tmr decrements each cycle. When Tmr==0: Tick=1 and Tmr <= INTERVAL-1. Period is exactly INTERVAL clocks.
  - The first tick after entering RUN comes INTERVAL clocks after the transition.
- Debt update, per cycle:
  - Tick && AckEdge: Debt unchanged (both events consumed).
  - Tick only: if Debt<MAX_DEBT, Debt+1; else Debt stays MAX_DEBT and Overrun <= 1.
  - AckEdge only: if Debt>0, Debt-1; at Debt==0 the edge is ignored (no underflow, no flag).
  - Overrun set has priority over OvrClr in the same cycle; otherwise OvrClr clears Overrun.
- Phase transitions:
  - INIT -> RUN on the cycle Debt changes 1 -> 0 via AckEdge; InitDone rises the next cycle.
  - RUN -> INIT only via reset. Reset mid-refresh discards all debt, reloads INIT_REFS, and repeats the init burst.
- Latency: RefReq/RefUrgent change the cycle after the Tick or AckEdge that moves Debt across a threshold.
- Width: Debt is clog2(MAX_DEBT+1) bits; Tmr is clog2(INTERVAL) bits. No arithmetic wraps in either.

Decomposition:
- Package refresh_pkg holds:
  - phase_t enum {PH_INIT, PH_RUN}.
  - Localparam helpers DEBT_W and TMR_W (clog2 widths).
  - Parameter legality checks as elaboration assertions.
- One sub-module, refresh_interval_timer:
  - Reloadable down-counter with hold input (held in INIT) and single-cycle Tick output.
  - Instantiated once.

Test Plan (bench parameters INTERVAL=10, MAX_DEBT=4, URGENT_TH=2, INIT_REFS=2):
- Init burst:
  - After reset: RefReq=1, RefUrgent=1, InitDone=0, Debt=2.
  - Two RefAck pulses, 2 cycles each, give Debt 1 then 0.
  - InitDone=1 and RefReq=0 one cycle after the second rising edge; no Tick during INIT.
- Periodic ticks, no acks after init:
  - Debt=1 at INTERVAL clocks after entering RUN (RefReq=1, RefUrgent=0).
  - Debt=2 at 20 clocks (RefUrgent=1); Debt=4 at 40 clocks.
  - Tick at 50 clocks: Debt stays 4 and Overrun=1.
  - OvrClr pulse clears Overrun.
- Long ack: with Debt=3, one RefAck held high 6 cycles -> Debt=2 (single decrement); RefUrgent stays 1.
- Simultaneous: RefAck rising edge in the same cycle as Tick with Debt=2 -> Debt stays 2; Overrun unchanged.
- Spurious ack at Debt=0 in RUN -> Debt stays 0; no flag.
- Reset mid-operation:
  - Assert nRESET low with Debt=3 and RefAck high in RUN.
  - Outputs return immediately to reset values.
  - On release with RefAck still high: no decrement until RefAck falls and rises again.
